// File: rtl/i2s_slave_trx.sv
// i2s_slave_trx
//   I2S slave transceiver running entirely in the clk_in domain. SCLK, LRCK and
//   receive data are oversampled (clk_in >= 8x SCLK) through synchronizer
//   chains; SCLK edges are detected in clk_in and drive both the receive
//   deserializer and the transmit serializer.
//
// Ports
//   clk_in      : system clock (only clock)
//   srst_in     : synchronous active-high reset
//   lrck_in     : external word clock, 0 = left, 1 = right (async)
//   sclk_in     : external bit clock (async)
//   sdata_in    : serial receive data (async)
//   sdata_out   : serial transmit data, MSB first, one SCLK after each LRCK edge
//   pldata_out  : last received left word (left-justified)
//   prdata_out  : last received right word (left-justified)
//   pvalid_out  : one-cycle pulse when a new left/right pair is presented
//   pldata_in   : left word to transmit
//   prdata_in   : right word to transmit
//   pload_out   : one-cycle pulse when pldata_in/prdata_in are latched
//   err_out     : one-cycle pulse when a completed word had the wrong bit count
module i2s_slave_trx #(
   parameter int PDATA_WIDTH = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   clk_in,
   input  logic                   srst_in,
   input  logic                   lrck_in,
   input  logic                   sclk_in,
   input  logic                   sdata_in,
   output logic                   sdata_out,
   output logic [PDATA_WIDTH-1:0] pldata_out,
   output logic [PDATA_WIDTH-1:0] prdata_out,
   output logic                   pvalid_out,
   input  logic [PDATA_WIDTH-1:0] pldata_in,
   input  logic [PDATA_WIDTH-1:0] prdata_in,
   output logic                   pload_out,
   output logic                   err_out
);

   localparam logic [6:0] LP_W   = 7'(PDATA_WIDTH);
   localparam logic [4:0] LP_MSB = 5'(PDATA_WIDTH - 1);

   typedef enum logic [1:0] {ST_HUNT, ST_LEFT, ST_RIGHT} state_t;

   logic [SYNC_STAGES-1:0] r_lrck_sync, r_sclk_sync, r_sdata_sync;
   logic                   r_sclk_d;
   logic                   r_lrck_prev;
   state_t                 r_state, w_state_nxt;
   logic                   r_armed;
   logic [5:0]             r_bit_cnt;
   logic [PDATA_WIDTH-1:0] r_rx_sh;
   logic [PDATA_WIDTH-1:0] r_pldata, r_prdata;
   logic                   r_pvalid, r_err;
   logic [PDATA_WIDTH-1:0] r_hold_l, r_hold_r, r_tx_sh;
   logic [5:0]             r_tx_cnt;
   logic                   r_sdata, r_pload;

   logic                   w_lrck, w_sclk, w_sdata;
   logic                   w_rise, w_fall, w_boundary;
   logic                   w_load, w_update;
   logic                   w_cnt_ok;
   logic [4:0]             w_idx;
   logic [6:0]             w_cnt_done;
   logic [PDATA_WIDTH-1:0] w_rx_word;

   // Synchronizers plus one extra SCLK register for edge detection
   always_ff @(posedge clk_in) begin
      if (srst_in) begin
         r_lrck_sync  <= '0;
         r_sclk_sync  <= '0;
         r_sdata_sync <= '0;
         r_sclk_d     <= 1'b0;
      end else begin
         r_lrck_sync  <= {r_lrck_sync[SYNC_STAGES-2:0], lrck_in};
         r_sclk_sync  <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_in};
         r_sdata_sync <= {r_sdata_sync[SYNC_STAGES-2:0], sdata_in};
         r_sclk_d     <= r_sclk_sync[SYNC_STAGES-1];
      end
   end

   assign w_lrck     = r_lrck_sync[SYNC_STAGES-1];
   assign w_sclk     = r_sclk_sync[SYNC_STAGES-1];
   assign w_sdata    = r_sdata_sync[SYNC_STAGES-1];
   assign w_rise     = w_sclk & ~r_sclk_d;
   assign w_fall     = ~w_sclk & r_sclk_d;
   // LRCK is only evaluated at rises, so a change seen at a fall waits for the next rise
   assign w_boundary = w_rise & (w_lrck ^ r_lrck_prev);

   // Receive/transmit state register
   always_ff @(posedge clk_in) begin
      if (srst_in) begin
         r_state     <= ST_HUNT;
         r_armed     <= 1'b0;
         r_lrck_prev <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_rise) r_lrck_prev <= w_lrck;
         // The word ending at the first boundary after HUNT started mid-stream
         if (w_boundary && r_state != ST_HUNT) r_armed <= 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_update    = 1'b0;
      if (w_boundary) begin
         w_state_nxt = w_lrck ? ST_RIGHT : ST_LEFT;
         if (r_state != ST_HUNT) begin
            w_load   = 1'b1;
            w_update = r_armed;
         end
      end
   end

   // The bit sampled on a boundary rise is the LSB slot of the outgoing word
   assign w_cnt_ok   = ({1'b0, r_bit_cnt} < LP_W);
   assign w_idx      = LP_MSB - r_bit_cnt[4:0];
   assign w_cnt_done = {1'b0, r_bit_cnt} + 7'd1;

   always_comb begin
      w_rx_word = r_rx_sh;
      if (w_cnt_ok) w_rx_word[w_idx] = w_sdata;
   end

   // Receive deserializer and parallel outputs
   always_ff @(posedge clk_in) begin
      if (srst_in) begin
         r_bit_cnt <= '0;
         r_rx_sh   <= '0;
         r_pldata  <= '0;
         r_prdata  <= '0;
         r_pvalid  <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_pvalid <= 1'b0;
         r_err    <= 1'b0;
         if (w_rise) begin
            if (w_boundary) begin
               r_bit_cnt <= '0;
               r_rx_sh   <= '0;
               if (w_update) begin
                  if (r_state == ST_RIGHT) begin
                     r_prdata <= w_rx_word;
                     r_pvalid <= 1'b1;
                  end else begin
                     r_pldata <= w_rx_word;
                  end
                  r_err <= (w_cnt_done != LP_W);
               end
            end else begin
               r_rx_sh <= w_rx_word;
               if (r_bit_cnt != 6'd63) r_bit_cnt <= r_bit_cnt + 6'd1;
            end
         end
      end
   end

   // Transmit serializer: left word is latched and loaded in the same cycle
   always_ff @(posedge clk_in) begin
      if (srst_in) begin
         r_hold_l <= '0;
         r_hold_r <= '0;
         r_tx_sh  <= '0;
         r_tx_cnt <= '0;
         r_sdata  <= 1'b0;
         r_pload  <= 1'b0;
      end else begin
         r_pload <= 1'b0;
         if (w_load) begin
            r_tx_cnt <= LP_W[5:0];
            if (!w_lrck) begin
               r_hold_l <= pldata_in;
               r_hold_r <= prdata_in;
               r_tx_sh  <= pldata_in;
               r_pload  <= 1'b1;
            end else begin
               r_tx_sh <= r_hold_r;
            end
         end else if (w_fall) begin
            if (r_tx_cnt != '0) begin
               r_sdata  <= r_tx_sh[PDATA_WIDTH-1];
               r_tx_sh  <= r_tx_sh << 1;
               r_tx_cnt <= r_tx_cnt - 6'd1;
            end else begin
               r_sdata <= 1'b0;
            end
         end
      end
   end

   assign sdata_out  = r_sdata;
   assign pldata_out = r_pldata;
   assign prdata_out = r_prdata;
   assign pvalid_out = r_pvalid;
   assign pload_out  = r_pload;
   assign err_out    = r_err;

endmodule

// File: tb/tb_i2s_slave_trx.sv
// tb_i2s_slave_trx
//   Drives I2S master traffic (SCLK = clk_in/8) into i2s_slave_trx and checks
//   received words, pulses and the transmitted bitstream against a word-level
//   reference model through scoreboard queues.
`timescale 1ns/1ps
module tb_i2s_slave_trx;

   localparam int W = 32;
   localparam int H = 40;

   typedef struct packed { logic [W-1:0] l; logic [W-1:0] r; } pair_t;
   typedef struct packed { logic ch; logic [W-1:0] w; } errw_t;

   logic          clk_in = 1'b0;
   logic          srst_in, lrck_drv, sclk_drv, sdata_drv, loop_en;
   logic          w_sdata_in;
   logic          sdata_out, pvalid_out, pload_out, err_out;
   logic [W-1:0]  pldata_out, prdata_out, pldata_in, prdata_in;

   always #5 clk_in = ~clk_in;
   assign w_sdata_in = loop_en ? sdata_out : sdata_drv;

   i2s_slave_trx #(.PDATA_WIDTH(W), .SYNC_STAGES(2)) dut (
      .clk_in(clk_in), .srst_in(srst_in), .lrck_in(lrck_drv), .sclk_in(sclk_drv),
      .sdata_in(w_sdata_in), .sdata_out(sdata_out), .pldata_out(pldata_out),
      .prdata_out(prdata_out), .pvalid_out(pvalid_out), .pldata_in(pldata_in),
      .prdata_in(prdata_in), .pload_out(pload_out), .err_out(err_out));

   int total = 0;
   int bad   = 0;

   pair_t exp_pair_q[$];
   errw_t exp_err_q[$];
   bit    exp_load_q[$];
   bit    tx_q[$];

   // Reference model state (word level)
   bit           m_hunt, m_armed, m_prev, m_txbit, last_lsb;
   bit           m_bits[$];
   logic [W-1:0] m_exp_l, m_hold_l, m_hold_r, m_tx_word;
   int           m_tx_pos;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_hunt = 1; m_armed = 0; m_prev = 0; m_bits.delete();
      m_exp_l = '0; m_hold_l = '0; m_hold_r = '0; m_tx_word = '0;
      m_tx_pos = W; m_txbit = 0;
   endtask

   task automatic finish_word(input bit old_ch);
      logic [W-1:0] w;
      int n;
      w = '0;
      n = m_bits.size();
      for (int i = 0; i < n && i < W; i++) w[W-1-i] = m_bits[i];
      if (!old_ch) m_exp_l = w;
      else exp_pair_q.push_back('{l: m_exp_l, r: w});
      if (n != W) exp_err_q.push_back('{ch: old_ch, w: w});
   endtask

   task automatic model_fall();
      if (m_tx_pos < W) m_txbit = m_tx_word[W-1-m_tx_pos];
      else              m_txbit = 0;
      m_tx_pos++;
   endtask

   task automatic model_rise(input bit l, input bit b);
      tx_q.push_back(m_txbit);
      m_bits.push_back(b);
      if (l != m_prev) begin
         if (m_hunt) m_hunt = 0;
         else begin
            if (m_armed) finish_word(m_prev);
            m_armed = 1;
            if (!l) begin
               m_hold_l = pldata_in;
               m_hold_r = prdata_in;
               exp_load_q.push_back(1);
            end
            m_tx_word = l ? m_hold_r : m_hold_l;
            m_tx_pos  = 0;
         end
         m_bits.delete();
      end
      m_prev = l;
   endtask

   // One SCLK period: master changes LRCK/data on the fall, slave samples on the rise
   task automatic period(input bit l, input bit d, input bit rst);
      lrck_drv = l; sdata_drv = d; sclk_drv = 0;
      model_fall();
      if (rst) begin
         #30;
         @(posedge clk_in); #1 srst_in = 1;
         @(posedge clk_in); #1 srst_in = 0;
         model_reset();
         #10;
      end else #H;
      sclk_drv = 1;
      model_rise(l, loop_en ? m_txbit : d);
      #H;
   endtask

   task automatic send_half(input bit ch, input logic [63:0] word, input int n,
                            input int rst_at, input bit rnd_tx);
      bit d;
      for (int k = 0; k < n; k++) begin
         d = (k == 0) ? last_lsb : word[n-k];
         period(ch, d, k == rst_at);
         if (rnd_tx && k == n/2) begin
            pldata_in = $urandom;
            prdata_in = $urandom;
         end
      end
      last_lsb = word[0];
   endtask

   // Pulse monitor
   always @(negedge clk_in) begin
      if (pvalid_out) begin
         if (exp_pair_q.size() == 0) check("pvalid_unexpected", 1, 0);
         else begin
            pair_t p;
            p = exp_pair_q.pop_front();
            check("pldata_out", pldata_out, p.l);
            check("prdata_out", prdata_out, p.r);
         end
      end
      if (err_out) begin
         if (exp_err_q.size() == 0) check("err_unexpected", 1, 0);
         else begin
            errw_t e;
            e = exp_err_q.pop_front();
            check("err_word", e.ch ? prdata_out : pldata_out, e.w);
         end
      end
      if (pload_out) begin
         check("pload_expected", exp_load_q.size() != 0, 1);
         if (exp_load_q.size() != 0) void'(exp_load_q.pop_front());
      end
   end

   // Transmit bitstream monitor: each period's bit is sampled just before the next fall
   always @(negedge sclk_drv) begin
      if (tx_q.size() != 0) begin
         bit b;
         b = tx_q.pop_front();
         check("sdata_out", sdata_out, b);
      end
   end

   initial begin
      srst_in = 1; sclk_drv = 0; lrck_drv = 0; sdata_drv = 0; loop_en = 0;
      pldata_in = '0; prdata_in = '0; last_lsb = 0;
      model_reset();
      repeat (3) @(negedge clk_in);
      check("rst_pldata", pldata_out, 0);
      check("rst_prdata", prdata_out, 0);
      check("rst_pvalid", pvalid_out, 0);
      check("rst_pload", pload_out, 0);
      check("rst_err", err_out, 0);
      check("rst_sdata", sdata_out, 0);
      @(posedge clk_in); #1 srst_in = 0;
      #($urandom_range(1, 9));

      // Full 32-bit frames with fixed transmit words
      pldata_in = 32'h8000_0001; prdata_in = 32'h7FFF_FFFE;
      repeat (3) begin
         send_half(0, 64'hA5A5_0001, 32, -1, 0);
         send_half(1, 64'h5A5A_0002, 32, -1, 0);
      end
      // Short 24-bit words
      repeat (3) begin
         send_half(0, 64'h12_3456, 24, -1, 0);
         send_half(1, 64'($urandom_range(0, 24'hFF_FFFF)), 24, -1, 0);
      end
      // Long 40-bit slots: truncated receive, zero padding on transmit
      repeat (2) begin
         send_half(0, {$urandom, $urandom} & 64'hFF_FFFF_FFFF, 40, -1, 1);
         send_half(1, {$urandom, $urandom} & 64'hFF_FFFF_FFFF, 40, -1, 0);
      end
      // Random 32-bit traffic
      repeat (3) begin
         send_half(0, 64'($urandom), 32, -1, 1);
         send_half(1, 64'($urandom), 32, -1, 0);
      end
      // Reset pulse in the middle of a left word
      send_half(0, 64'($urandom), 32, 10, 0);
      send_half(1, 64'($urandom), 32, -1, 0);
      repeat (3) begin
         send_half(0, 64'($urandom), 32, -1, 1);
         send_half(1, 64'($urandom), 32, -1, 0);
      end
      // Loopback of sdata_out into sdata_in with a shifted phase
      #($urandom_range(1, 9));
      loop_en = 1;
      repeat (5) begin
         send_half(0, 64'd0, 32, -1, 1);
         send_half(1, 64'd0, 32, -1, 0);
      end
      loop_en = 0;
      send_half(0, 64'd0, 4, -1, 0);
      sclk_drv = 0;
      #200;
      check("pairs_pending", exp_pair_q.size(), 0);
      check("errs_pending", exp_err_q.size(), 0);
      check("loads_pending", exp_load_q.size(), 0);
      check("txbits_pending", tx_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/i2s_slave_trx.md
I2S_SLAVE_TRX -- requirements
Module: i2s_slave_trx

Interface
REQ-001 SHALL have parameter PDATA_WIDTH, default 32: bits per channel word, range 8..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on lrck_in, sclk_in and sdata_in, range 2..3.
REQ-003 SHALL have port clk_in, input, 1 bit: the only clock, at least 8x the SCLK frequency.
REQ-004 SHALL have port srst_in, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port lrck_in, input, 1 bit: external word clock (0 = left, 1 = right), asynchronous.
REQ-006 SHALL have port sclk_in, input, 1 bit: external bit clock, asynchronous.
REQ-007 SHALL have port sdata_in, input, 1 bit: serial receive data, asynchronous.
REQ-008 SHALL have port sdata_out, output, 1 bit: serial transmit data.
REQ-009 SHALL have port pldata_out, output, PDATA_WIDTH bits: last received left word.
REQ-010 SHALL have port prdata_out, output, PDATA_WIDTH bits: last received right word.
REQ-011 SHALL have port pvalid_out, output, 1 bit: one-cycle pulse when a new left/right pair is on the outputs.
REQ-012 SHALL have port pldata_in, input, PDATA_WIDTH bits: left word to transmit.
REQ-013 SHALL have port prdata_in, input, PDATA_WIDTH bits: right word to transmit.
REQ-014 SHALL have port pload_out, output, 1 bit: one-cycle pulse when pldata_in/prdata_in are latched.
REQ-015 SHALL have port err_out, output, 1 bit: one-cycle pulse when a completed word had a bit count other than PDATA_WIDTH.

Function
REQ-016 SHALL pass lrck_in, sclk_in and sdata_in through identical SYNC_STAGES flop chains, then one more register on SCLK for edge detection.
REQ-017 SHALL define rise = synchronized SCLK 0->1 and fall = synchronized SCLK 1->0, each lasting one clk_in cycle.
REQ-018 SHALL compare the synchronized LRCK on each rise with its value at the previous rise; a difference is a "boundary".
REQ-019 On each rise, receive SHALL store sdata at bit index PDATA_WIDTH-1-bit_cnt while bit_cnt < PDATA_WIDTH; later bits are ignored.
REQ-020 On each rise, bit_cnt SHALL saturate at 63.
REQ-021 On a boundary rise, the sampled bit SHALL be the last bit (LSB slot) of the outgoing word (I2S one-bit delay); bit_cnt then resets to 0 and the shift register clears.
REQ-022 A boundary rise with the old LRCK = 0 SHALL copy the shift register to pldata_out on the following clk_in cycle.
REQ-023 A boundary rise with the old LRCK = 1 SHALL copy the shift register to prdata_out on the following clk_in cycle and pulse pvalid_out in that same cycle.
REQ-024 Words shorter than PDATA_WIDTH SHALL be left-justified and zero-padded; err_out SHALL pulse alongside the copy whenever the completed word's bit count != PDATA_WIDTH.
REQ-025 Receive state machine: HUNT (from reset, until the first boundary, with no outputs updated) -> LEFT/RIGHT, tracking the LRCK level.
REQ-026 The first word after HUNT SHALL be discarded; output updates, pvalid_out and err_out SHALL begin at the second boundary.
REQ-027 On a boundary rise with the new LRCK = 0, transmit SHALL latch pldata_in and prdata_in into holding registers and pulse pload_out.
REQ-028 On every boundary rise, transmit SHALL load the tx shift register from the left holding register if the new LRCK = 0, else from the right holding register.
REQ-029 The latch (REQ-027) and the load (REQ-028) SHALL occur in the same cycle, so the left word is the newly latched value.
REQ-030 On each fall, sdata_out SHALL present the next bit MSB-first; the first fall after a load presents the MSB.
REQ-031 After PDATA_WIDTH bits, sdata_out SHALL be 0 until the next load.
REQ-032 sdata_out SHALL change within SYNC_STAGES+2 clk_in cycles of the physical SCLK falling edge.
REQ-033 In HUNT, sdata_out SHALL be 0 and no loads SHALL occur.
REQ-034 A simultaneous rise/fall is impossible by construction; an LRCK change seen at a fall SHALL NOT be acted on until the next rise.

Reset
REQ-035 While srst_in = 1 at a clk_in edge: pldata_out, prdata_out, shift and holding registers = 0; sdata_out, pvalid_out, pload_out, err_out = 0; bit_cnt = 0; state = HUNT; synchronizers = 0.
REQ-036 Reset asserted mid-word SHALL abort the word with no output update; after release the block re-enters HUNT and discards the first word.

Verification
REQ-037 Reset, then three 64-SCLK frames: left 0xA5A5_0001, right 0x5A5A_0002 -> pvalid_out once per frame from frame 2, with pldata_out = 0xA5A5_0001 and prdata_out = 0x5A5A_0002.
REQ-038 pldata_in = 0x8000_0001, prdata_in = 0x7FFF_FFFE -> pload_out at each left boundary; sdata_out bitstream MSB-first, starting one SCLK after each LRCK edge, matches both words, followed by 0 padding.
REQ-039 24-bit words (48-SCLK frames), left 0x123456 -> pldata_out = 0x1234_5600, err_out pulses with each copy.
REQ-040 srst_in pulsed for 1 cycle mid-left-word -> no pvalid_out for that frame or the next; correct data resumes at the following frame.
REQ-041 clk_in/SCLK ratio 8, with random phase between sdata_out loopback into sdata_in -> received words equal transmitted words after HUNT.
